// File: rtl/instr_dispatch_scoreboard.sv
// In-order dispatcher: holds one decoded instruction, tracks outstanding
// execution units and issues over a valid/ready handshake once hazards clear.
module instr_dispatch_scoreboard #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_REGS          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INSTRUCTION_WIDTH-1:0]  instr_in,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  output logic [4:0]                    unit_valid,
  input  logic [4:0]                    unit_ready,
  input  logic [4:0]                    unit_done,
  output logic [3:0]                    opcode_function,
  output logic [$clog2(NUM_REGS)-1:0]   buffer_address,
  output logic [15:0]                   memory_address,
  output logic [4:0]                    busy_units,
  output logic                          idle,
  output logic                          err_illegal,
  output logic                          err_done,
  output logic [7:0]                    illegal_count
);

  localparam int BW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_ISSUE
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     hold_q, hold_d;
  logic [4:0]      uv_q, uv_d;
  logic [4:0]      busy_q, busy_d;
  logic [3:0]      func_q, func_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   rl_addr_q, rl_addr_d;
  logic [15:0]     mem_q, mem_d;
  logic            err_ill_q, err_ill_d;
  logic            err_done_q, err_done_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [7:0]      opcode;
  logic [BW-1:0]   hold_buf;
  logic            legal;
  logic [4:0]      hazard;
  logic            stall;
  logic            handshake;

  if (INSTRUCTION_WIDTH > 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^instr_in[INSTRUCTION_WIDTH-1:32];
  end

  assign opcode    = hold_q[7:0];
  assign hold_buf  = hold_q[12 +: BW];
  assign legal     = (opcode[7:5] == 3'b000) && $onehot(opcode[4:0]);

  // Hazards look only at registered busy/lock state; done pulses are not bypassed.
  assign hazard[0] = busy_q[0];
  assign hazard[1] = busy_q[1] | (busy_q[0] && (rl_addr_q == hold_buf));
  assign hazard[2] = busy_q[2] | busy_q[1];
  assign hazard[3] = busy_q[3] | busy_q[2];
  assign hazard[4] = busy_q[4] | busy_q[3];
  assign stall     = |(opcode[4:0] & hazard);

  // uv_q is non-zero only in S_ISSUE, so this is the issue handshake.
  assign handshake   = |(uv_q & unit_ready);
  assign instr_ready = (state_q == S_EMPTY) || ((state_q == S_ISSUE) && handshake);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    uv_d       = uv_q;
    func_d     = func_q;
    buf_d      = buf_q;
    mem_d      = mem_q;
    rl_addr_d  = rl_addr_q;
    cnt_d      = cnt_q;
    err_ill_d  = 1'b0;
    busy_d     = busy_q & ~unit_done;
    err_done_d = |(unit_done & ~busy_q);

    case (state_q)
      S_EMPTY: begin
        if (instr_valid) begin
          hold_d  = instr_in[31:0];
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!legal) begin
          err_ill_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          state_d = S_EMPTY;
        end else if (!stall) begin
          uv_d    = opcode[4:0];
          func_d  = hold_q[11:8];
          buf_d   = hold_buf;
          mem_d   = hold_q[31:16];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          busy_d = busy_d | uv_q;
          if (uv_q[0]) rl_addr_d = buf_q;
          uv_d = '0;
          // The handshake cycle doubles as an accept slot for the next instruction.
          if (instr_valid) begin
            hold_d  = instr_in[31:0];
            state_d = S_WAIT;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      hold_q     <= '0;
      uv_q       <= '0;
      busy_q     <= '0;
      func_q     <= '0;
      buf_q      <= '0;
      mem_q      <= '0;
      rl_addr_q  <= '0;
      err_ill_q  <= 1'b0;
      err_done_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      uv_q       <= uv_d;
      busy_q     <= busy_d;
      func_q     <= func_d;
      buf_q      <= buf_d;
      mem_q      <= mem_d;
      rl_addr_q  <= rl_addr_d;
      err_ill_q  <= err_ill_d;
      err_done_q <= err_done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign unit_valid      = uv_q;
  assign opcode_function = func_q;
  assign buffer_address  = buf_q;
  assign memory_address  = mem_q;
  assign busy_units      = busy_q;
  assign idle            = (state_q == S_EMPTY) && (busy_q == '0);
  assign err_illegal     = err_ill_q;
  assign err_done        = err_done_q;
  assign illegal_count   = cnt_q;

endmodule

// File: tb/tb_instr_dispatch_scoreboard.sv
// Bench for instr_dispatch_scoreboard: vector table, scoreboard of expected
// issues checked at each handshake, and hand-written multi-cycle sequences.
module tb_instr_dispatch_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  unit_valid;
  logic [4:0]  unit_ready;
  logic [4:0]  unit_done;
  logic [3:0]  opcode_function;
  logic [3:0]  buffer_address;
  logic [15:0] memory_address;
  logic [4:0]  busy_units;
  logic        idle;
  logic        err_illegal;
  logic        err_done;
  logic [7:0]  illegal_count;

  logic [4:0]  man_done;
  logic [4:0]  mdl_done;
  logic        mdl_en;

  assign unit_done = man_done | mdl_done;

  instr_dispatch_scoreboard #(
    .INSTRUCTION_WIDTH(32),
    .NUM_REGS(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_in(instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .unit_valid(unit_valid),
    .unit_ready(unit_ready),
    .unit_done(unit_done),
    .opcode_function(opcode_function),
    .buffer_address(buffer_address),
    .memory_address(memory_address),
    .busy_units(busy_units),
    .idle(idle),
    .err_illegal(err_illegal),
    .err_done(err_done),
    .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [4:0]  u;
    logic [3:0]  f;
    logic [3:0]  b;
    logic [15:0] m;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  unit;
    logic [3:0]  func;
    logic [3:0]  bufa;
    logic [15:0] mem;
    logic        ill;
  } vec_t;

  vec_t vt[8];
  int   exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [4:0] u, input logic [3:0] f, input logic [3:0] b,
                      input logic [15:0] m);
    exp_t e;
    e.u = u; e.f = f; e.b = b; e.m = m;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [31:0] ins);
    instr_in    = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic hs(input logic [4:0] u);
    unit_ready = u;
    tick();
    unit_ready = '0;
  endtask

  task automatic pulse_done(input logic [4:0] u);
    man_done = u;
    tick();
    man_done = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", 32'(instr_ready), 32'd1);
  endtask

  // Scoreboard: every handshake must match the oldest expected issue.
  initial begin
    exp_t e;
    logic [4:0] m;
    forever begin
      @(negedge clk);
      if (rst_n && ((unit_valid & unit_ready) != '0)) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'(unit_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_issue", {3'b0, unit_valid, opcode_function, buffer_address, memory_address},
              {3'b0, e});
          m = (unit_valid[4:2] != '0) ? (unit_valid | (unit_valid >> 1)) : unit_valid;
          chk("hazard_clear", 32'(busy_units & m), 32'd0);
        end
      end
    end
  end

  // Unit model: assert done roughly 10 cycles after each handshake.
  initial begin
    int dcnt[5];
    logic [4:0] hsv;
    for (int i = 0; i < 5; i++) dcnt[i] = 0;
    mdl_done = '0;
    forever begin
      @(negedge clk);
      hsv = unit_valid & unit_ready & {5{mdl_en}};
      @(posedge clk);
      #2;
      mdl_done = '0;
      for (int i = 0; i < 5; i++) begin
        if (dcnt[i] != 0) begin
          dcnt[i]--;
          if (dcnt[i] == 0) mdl_done[i] = 1'b1;
        end
      end
      for (int i = 0; i < 5; i++) if (hsv[i]) dcnt[i] = 10;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] ci;

    rst_n       = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    unit_ready  = '0;
    man_done    = '0;
    mdl_en      = 1'b0;

    vt[0] = '{32'h1234_5301, 5'b00001, 4'h3, 4'h5, 16'h1234, 1'b0};
    vt[1] = '{32'hABCD_6A02, 5'b00010, 4'hA, 4'h6, 16'hABCD, 1'b0};
    vt[2] = '{32'h0001_F704, 5'b00100, 4'h7, 4'hF, 16'h0001, 1'b0};
    vt[3] = '{32'hFFFF_0008, 5'b01000, 4'h0, 4'h0, 16'hFFFF, 1'b0};
    vt[4] = '{32'h5A5A_9C10, 5'b10000, 4'hC, 4'h9, 16'h5A5A, 1'b0};
    vt[5] = '{32'h0000_0000, 5'b00000, 4'h0, 4'h0, 16'h0000, 1'b1};
    vt[6] = '{32'h0000_0003, 5'b00000, 4'h0, 4'h0, 16'h0000, 1'b1};
    vt[7] = '{32'h0000_0020, 5'b00000, 4'h0, 4'h0, 16'h0000, 1'b1};

    // Reset state
    #12;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_unit_valid", 32'(unit_valid), 32'd0);
    chk("rst_busy", 32'(busy_units), 32'd0);
    chk("rst_count", 32'(illegal_count), 32'd0);
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
    chk("rst_err_done", 32'(err_done), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // Vector table: single instructions from idle
    for (int i = 0; i < 8; i++) begin
      if (!vt[i].ill) push(vt[i].unit, vt[i].func, vt[i].bufa, vt[i].mem);
      send(vt[i].instr);
      chk("vec_wait_not_ready", 32'(instr_ready), 32'd0);
      tick();
      if (vt[i].ill) begin
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        chk("vec_err_illegal", 32'(err_illegal), 32'd1);
        chk("vec_ill_count", 32'(illegal_count), 32'(exp_cnt));
        chk("vec_ill_no_issue", 32'(unit_valid), 32'd0);
        tick();
        chk("vec_err_illegal_pulse", 32'(err_illegal), 32'd0);
        chk("vec_ill_idle", 32'(idle), 32'd1);
      end else begin
        chk("vec_issue_latency", 32'(unit_valid), 32'(vt[i].unit));
        hs(vt[i].unit);
        chk("vec_busy_after_hs", 32'(busy_units), 32'(vt[i].unit));
        chk("vec_valid_dropped", 32'(unit_valid), 32'd0);
        pulse_done(vt[i].unit);
        chk("vec_busy_cleared", 32'(busy_units), 32'd0);
        chk("vec_idle", 32'(idle), 32'd1);
        chk("vec_no_err_done", 32'(err_done), 32'd0);
      end
    end

    // RAW: weight_load on the same buffer as an outstanding reg_load
    push(5'b00001, 4'h0, 4'h5, 16'h0000);
    send(32'h0000_5001);
    tick();
    hs(5'b00001);
    chk("raw_rl_busy", 32'(busy_units), 32'd1);
    push(5'b00010, 4'h0, 4'h5, 16'h0000);
    send(32'h0000_5002);
    repeat (4) tick();
    chk("raw_stall_valid", 32'(unit_valid), 32'd0);
    chk("raw_stall_ready", 32'(instr_ready), 32'd0);
    pulse_done(5'b00001);
    chk("raw_no_bypass", 32'(unit_valid), 32'd0);
    chk("raw_busy_cleared", 32'(busy_units), 32'd0);
    tick();
    chk("raw_release", 32'(unit_valid), 32'b00010);
    hs(5'b00010);
    pulse_done(5'b00010);

    // Different buffer: no stall; done of reg_load coincides with weight handshake
    push(5'b00001, 4'h0, 4'h5, 16'h0000);
    send(32'h0000_5001);
    tick();
    hs(5'b00001);
    push(5'b00010, 4'h0, 4'h6, 16'h0000);
    send(32'h0000_6002);
    tick();
    chk("nostall_buf6", 32'(unit_valid), 32'b00010);
    unit_ready = 5'b00010;
    man_done   = 5'b00001;
    tick();
    unit_ready = '0;
    man_done   = '0;
    chk("done_and_issue_busy", 32'(busy_units), 32'b00010);
    chk("done_and_issue_err", 32'(err_done), 32'd0);
    pulse_done(5'b00010);
    chk("done_and_issue_idle", 32'(idle), 32'd1);

    // Accept during the issue handshake cycle
    push(5'b00001, 4'h1, 4'h2, 16'h0003);
    send(32'h0003_2101);
    tick();
    chk("hsacc_first_issue", 32'(unit_valid), 32'b00001);
    push(5'b01000, 4'h4, 4'h0, 16'hBEEF);
    instr_in    = 32'hBEEF_0408;
    instr_valid = 1'b1;
    unit_ready  = 5'b00001;
    #1;
    chk("hsacc_ready_in_issue", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    unit_ready  = '0;
    chk("hsacc_now_wait", 32'(instr_ready), 32'd0);
    chk("hsacc_busy", 32'(busy_units), 32'b00001);
    tick();
    chk("hsacc_second_issue", 32'(unit_valid), 32'b01000);
    hs(5'b01000);
    pulse_done(5'b01001);
    chk("hsacc_idle", 32'(idle), 32'd1);

    // Done for a non-busy unit
    pulse_done(5'b10000);
    chk("errdone_pulse", 32'(err_done), 32'd1);
    chk("errdone_busy", 32'(busy_units), 32'd0);
    tick();
    chk("errdone_pulse_end", 32'(err_done), 32'd0);

    // Full chain with always-ready units and delayed done
    mdl_en     = 1'b1;
    unit_ready = '1;
    for (int i = 0; i < 5; i++) begin
      ci = {16'(16'h0100 + i), 4'h3, 4'(i), 8'(1 << i)};
      push(5'(1 << i), 4'(i), 4'h3, 16'(16'h0100 + i));
      wait_ready();
      send(ci);
    end
    n = 0;
    while (!idle && n < 300) begin
      tick();
      n++;
    end
    chk("chain_idle", 32'(idle), 32'd1);
    chk("chain_all_issued", 32'(sbq.size()), 32'd0);
    mdl_en     = 1'b0;
    unit_ready = '0;
    tick();

    // Illegal flood: counter saturates
    repeat (260) begin
      send(32'h0000_0000);
      tick();
    end
    chk("ill_saturate", 32'(illegal_count), 32'd255);
    chk("ill_flood_idle", 32'(idle), 32'd1);

    // Asynchronous reset in the middle of an issue
    push(5'b00001, 4'h0, 4'h0, 16'h0000);
    send(32'h0000_0001);
    tick();
    hs(5'b00001);
    send(32'h0000_0004);
    tick();
    chk("midrst_issuing", 32'(unit_valid), 32'b00100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(unit_valid), 32'd0);
    chk("midrst_busy", 32'(busy_units), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_count", 32'(illegal_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
